// File: rtl/wave_capture.sv
// ============================================================================
// Module      : wave_capture
// Description : Writer side of the dual-half wave RAM. Arms on a rising zero
//               crossing, stores 256 offset-binary samples into the hidden
//               half, then swaps halves once the display is idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_capture #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W-1:0]   write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [ADDR_W-2:0] c_last_count = '1;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-2:0]   r_count;
  logic                r_prev_neg;
  logic                r_read_index;
  logic                r_write_enable;
  logic [ADDR_W-1:0]   r_write_address;
  logic [7:0]          r_write_sample;

  logic                w_trigger;
  logic                w_do_write;
  logic                w_swap;
  logic [7:0]          w_converted;
  logic                w_unused_low_bits;

  // Top byte of the sample with the sign bit flipped gives offset binary.
  assign w_converted       = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]};
  assign w_unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_ARMED;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_trigger    = 1'b0;
    w_do_write   = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      S_ARMED: begin
        if (new_sample_ready && r_prev_neg && !new_sample_in[SAMPLE_W-1]) begin
          w_trigger    = 1'b1;
          w_next_state = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (new_sample_ready) begin
          w_do_write = 1'b1;
          if (r_count == c_last_count) begin
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wave_display_idle) begin
          w_swap       = 1'b1;
          w_next_state = S_ARMED;
        end
      end
      default: begin
        w_next_state = S_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count         <= '0;
      r_prev_neg      <= 1'b0;
      r_read_index    <= 1'b0;
      r_write_enable  <= 1'b0;
      r_write_address <= '0;
      r_write_sample  <= 8'h00;
    end else begin
      r_write_enable <= w_do_write;
      if (new_sample_ready) begin
        r_prev_neg <= new_sample_in[SAMPLE_W-1];
      end
      // Count wraps naturally to 0 after the 256th write.
      if (w_trigger) begin
        r_count <= '0;
      end else if (w_do_write) begin
        r_count <= r_count + 1'b1;
      end
      if (w_do_write) begin
        r_write_address <= {~r_read_index, r_count};
        r_write_sample  <= w_converted;
      end
      if (w_swap) begin
        r_read_index <= ~r_read_index;
      end
    end
  end

  assign write_address = r_write_address;
  assign write_enable  = r_write_enable;
  assign write_sample  = r_write_sample;
  assign read_index    = r_read_index;

endmodule

`default_nettype wire

// File: tb/tb_wave_capture.sv
// ============================================================================
// Module      : tb_wave_capture
// Description : Self-checking bench for wave_capture: directed vector table,
//               corner sequences and random stimulus against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wave_capture;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_capture #(.SAMPLE_W(16), .ADDR_W(9)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: capture phase, samples stored so far, displayed half.
  int m_mode;      // 0 armed, 1 capturing, 2 waiting for idle
  int m_n;
  int m_half;
  bit m_prev_lt0;
  int exp_we, exp_addr, exp_ws;

  int we_count;
  int last_addr;

  typedef struct {
    logic        rdy;
    logic [15:0] smp;
    logic        idl;
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  ws;
    logic        ri;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_half = 0; m_prev_lt0 = 0;
    exp_we = 0; exp_addr = 0; exp_ws = 0;
  endtask

  task automatic model_update(input logic rdy, input logic [15:0] s, input logic idl);
    int sv;
    sv = int'($signed(s));
    exp_we = 0;
    case (m_mode)
      0: if (rdy && m_prev_lt0 && sv >= 0) begin m_mode = 1; m_n = 0; end
      1: if (rdy) begin
           exp_we   = 1;
           exp_addr = (1 - m_half) * 256 + m_n;
           exp_ws   = (sv + 32768) / 256;
           m_n++;
           if (m_n == 256) m_mode = 2;
         end
      default: if (idl) begin m_half = 1 - m_half; m_mode = 0; end
    endcase
    if (rdy) m_prev_lt0 = (sv < 0);
  endtask

  task automatic check_model();
    check("write_enable", int'(write_enable), exp_we);
    check("write_address", int'(write_address), exp_addr);
    check("write_sample", int'(write_sample), exp_ws);
    check("read_index", int'(read_index), m_half);
  endtask

  // Called from a negedge; drives inputs, clocks once, checks #1 after edge.
  task automatic step(input logic rdy, input logic [15:0] s, input logic idl);
    new_sample_ready  = rdy;
    new_sample_in     = s;
    wave_display_idle = idl;
    @(posedge clk);
    model_update(rdy, s, idl);
    #1;
    check_model();
    if (write_enable) begin
      we_count++;
      last_addr = int'(write_address);
    end
    @(negedge clk);
  endtask

  // Stream n random samples, with gaps, until n strobes have been issued.
  task automatic stream(input int n);
    int sent;
    sent = 0;
    while (sent < n) begin
      if ($urandom_range(3) != 0) begin
        step(1'b1, 16'($urandom), 1'b0);
        sent++;
      end else begin
        step(1'b0, 16'($urandom), 1'b0);
      end
    end
    step(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0100, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 16'hFF00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 16'h0200, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 16'h1234, 1'b0, 1'b1, 9'h100, 8'h92, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 9'h100, 8'h92, 1'b0};

    new_sample_ready = 0; new_sample_in = 0; wave_display_idle = 0;
    reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_model();
    reset = 1;
    @(negedge clk);

    // Directed trigger and first write.
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].rdy, vecs[i].smp, vecs[i].idl);
      check($sformatf("vec%0d_we", i), int'(write_enable), int'(vecs[i].we));
      check($sformatf("vec%0d_addr", i), int'(write_address), int'(vecs[i].addr));
      check($sformatf("vec%0d_ws", i), int'(write_sample), int'(vecs[i].ws));
      check($sformatf("vec%0d_ri", i), int'(read_index), int'(vecs[i].ri));
    end

    // Remaining 255 writes of the first capture, then a 257th strobe.
    we_count = 1;
    stream(255);
    check("capture0_writes", we_count, 256);
    check("capture0_last_addr", last_addr, 9'h1FF);
    step(1'b1, 16'h0300, 1'b0);
    check("strobe257_no_write", int'(write_enable), 0);

    // Display stays busy: no swap.
    for (int i = 0; i < 1000; i++) step(1'b0, 16'h0000, 1'b0);
    check("busy_read_index", int'(read_index), 0);
    step(1'b0, 16'h0000, 1'b1);
    check("swap_read_index", int'(read_index), 1);

    // Second capture goes to the lower half.
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h0001, 1'b0);
    we_count = 0;
    stream(256);
    check("capture1_writes", we_count, 256);
    check("capture1_last_addr", last_addr, 9'h0FF);

    // Swap coinciding with a rising sample: no trigger that cycle.
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h0100, 1'b1);
    check("coincide_read_index", int'(read_index), 0);
    step(1'b1, 16'h0200, 1'b0);
    check("coincide_no_write", int'(write_enable), 0);
    step(1'b1, 16'hFF00, 1'b0);
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h4000, 1'b0);
    check("retrigger_we", int'(write_enable), 1);
    check("retrigger_addr", int'(write_address), 9'h100);
    check("retrigger_ws", int'(write_sample), 8'hC0);
    stream(255);
    step(1'b1, 16'h0400, 1'b1);
    check("swap2_read_index", int'(read_index), 1);

    // Extreme values: positives never trigger, then -32768 -> 32767 does.
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0400, 1'b0);
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h7FFF, 1'b0);
    check("extreme_trigger_no_write", int'(write_enable), 0);
    step(1'b1, 16'h8000, 1'b0);
    check("min_ws", int'(write_sample), 8'h00);
    check("min_addr", int'(write_address), 9'h000);
    step(1'b1, 16'h7FFF, 1'b0);
    check("max_ws", int'(write_sample), 8'hFF);
    check("max_addr", int'(write_address), 9'h001);
    step(1'b1, 16'hFFFF, 1'b0);
    check("neg1_ws", int'(write_sample), 8'h7F);
    step(1'b1, 16'h0000, 1'b0);
    check("zero_ws", int'(write_sample), 8'h80);
    stream(96);

    // Asynchronous reset mid-capture at count 100.
    step(1'b1, 16'h1111, 1'b0);
    reset = 0;
    #1;
    model_reset();
    check("async_reset_we", int'(write_enable), 0);
    check("async_reset_ri", int'(read_index), 0);
    @(negedge clk);
    reset = 1;
    step(1'b1, 16'h0100, 1'b0);
    check("post_reset_no_trigger", int'(write_enable), 0);
    step(1'b1, 16'hFF00, 1'b0);
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h2000, 1'b0);
    check("restart_addr", int'(write_address), 9'h100);
    check("restart_we", int'(write_enable), 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
